// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller.
// Drives a single-port memory with a 1-cycle registered write-data path and a
// 2-cycle read latency. It compares every read against the value the March
// element expects, and reports pass/fail together with the first failing
// address, data and element.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int CAPACITY     = 15,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [2:0]            fail_elem,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] ONES      = '1;
  localparam logic [DATA_WIDTH-1:0] ZEROS     = '0;

  // Elements 3 and 4 sweep the addresses downwards; all other elements sweep upwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Value that each element writes: w1 in E1 and E3, and w0 in every other element.
  function automatic logic [DATA_WIDTH-1:0] write_value(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? ONES : ZEROS;
  endfunction

  // Value that each element expects to read: r1 in E2 and E4, and r0 in every other element.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? ONES : ZEROS;
  endfunction

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    drain_q, drain_d;
  logic                    fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic                    s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]   s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
  logic [ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [2:0]              s1_elem_q, s1_elem_d, s2_elem_q, s2_elem_d;

  logic                    last_addr;
  logic [ADDR_WIDTH-1:0]   addr_step;
  logic [2:0]              next_elem;
  logic                    push;
  logic                    mismatch;
  logic                    abort;
  logic                    accept;

  // Sequence the March elements. The address counter stops at the element
  // boundary and never wraps.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    drain_d   = drain_q;
    push      = 1'b0;
    next_elem = elem_q + 3'd1;
    last_addr = elem_down(elem_q) ? (addr_q == '0) : (addr_q == LAST_ADDR);
    addr_step = elem_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    mismatch  = s2_valid_q && (mem_rdata != s2_exp_q);
    abort     = (STOP_ON_FAIL != 0) && mismatch && !fail_q;
    accept    = ((state_q == IDLE) || (state_q == DONE)) && start;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETUP;
          elem_d  = 3'd0;
          addr_d  = '0;
          wdata_d = write_value(3'd0);
        end
      end
      SETUP: begin
        state_d = (elem_q == 3'd0) ? WRITE : READ;
      end
      READ: begin
        push = 1'b1;
        if (elem_q == 3'd5) begin
          if (last_addr) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end else begin
            addr_d = addr_step;
          end
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (last_addr) begin
          state_d = SETUP;
          elem_d  = next_elem;
          addr_d  = elem_down(next_elem) ? LAST_ADDR : '0;
          wdata_d = (next_elem == 3'd5) ? wdata_q : write_value(next_elem);
        end else begin
          addr_d  = addr_step;
          state_d = (elem_q == 3'd0) ? WRITE : READ;
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = DONE;
  end

  // Two-stage compare pipeline that lines each read up with the memory's
  // 2-cycle read latency. An abort flushes any compares still in flight.
  always_comb begin
    s1_valid_d = push && !abort;
    s1_exp_d   = read_value(elem_q);
    s1_addr_d  = addr_q;
    s1_elem_d  = elem_q;
    s2_valid_d = s1_valid_q && !abort;
    s2_exp_d   = s1_exp_q;
    s2_addr_d  = s1_addr_q;
    s2_elem_d  = s1_elem_q;
  end

  // Capture the first miscompare and keep it until the next accepted start.
  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = s2_addr_q;
      fail_data_d = mem_rdata;
      fail_elem_d = s2_elem_q;
    end
    if (accept) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_data_d = '0;
      fail_elem_d = '0;
    end
  end

  // State, address, data and compare registers, all with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drain_q     <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_exp_q    <= '0;
      s1_addr_q   <= '0;
      s1_elem_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_exp_q    <= '0;
      s2_addr_q   <= '0;
      s2_elem_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      drain_q     <= drain_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
      s1_valid_q  <= s1_valid_d;
      s1_exp_q    <= s1_exp_d;
      s1_addr_q   <= s1_addr_d;
      s1_elem_q   <= s1_elem_d;
      s2_valid_q  <= s2_valid_d;
      s2_exp_q    <= s2_exp_d;
      s2_addr_q   <= s2_addr_d;
      s2_elem_q   <= s2_elem_d;
    end
  end

  // Outputs decode the registered state. The write strobe is also masked by
  // rst, so that no write reaches the memory in the cycle that reset is applied.
  always_comb begin
    busy           = (state_q != IDLE) && (state_q != DONE);
    done           = (state_q == DONE);
    fail           = fail_q;
    fail_addr      = fail_addr_q;
    fail_data      = fail_data_q;
    fail_elem      = fail_elem_q;
    mem_write_read = (state_q == WRITE) && !rst;
    mem_address    = addr_q;
    mem_wdata      = wdata_q;
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl. It uses three controller instances:
// 0 = CAPACITY 3 that continues after a fail; 1 = CAPACITY 3 that stops on a fail;
// 2 = the full 16-word space.
// Each instance drives its own behavioural memory. That memory has a registered
// write-data path, a 2-cycle read latency and an optional stuck-at-0 on bit 2 of address 2.
module tb_mbist_march_ctrl;

  logic       clk = 1'b0;
  logic       rst [3];
  logic       start [3];
  logic       busy [3];
  logic       done [3];
  logic       fail [3];
  logic [3:0] fail_addr [3];
  logic [7:0] fail_data [3];
  logic [2:0] fail_elem [3];
  logic       mem_wr [3];
  logic [3:0] mem_addr [3];
  logic [7:0] mem_wdata [3];
  logic [7:0] rd1 [3];
  logic [7:0] rd2 [3];
  logic [7:0] wdata_reg [3];
  logic [7:0] mem_array [3][16];
  logic       fault [3];

  int checks = 0;
  int errors = 0;
  int exp_wr[$];
  int exp_addr[$];
  int exp_data[$];

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(3), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]), .fail(fail[0]),
    .fail_addr(fail_addr[0]), .fail_data(fail_data[0]), .fail_elem(fail_elem[0]),
    .mem_write_read(mem_wr[0]), .mem_address(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(rd2[0]));

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(3), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]), .fail(fail[1]),
    .fail_addr(fail_addr[1]), .fail_data(fail_data[1]), .fail_elem(fail_elem[1]),
    .mem_write_read(mem_wr[1]), .mem_address(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(rd2[1]));

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .done(done[2]), .fail(fail[2]),
    .fail_addr(fail_addr[2]), .fail_data(fail_data[2]), .fail_elem(fail_elem[2]),
    .mem_write_read(mem_wr[2]), .mem_address(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .mem_rdata(rd2[2]));

  // Behavioural memories: write data is registered one cycle before use, and read data appears two cycles after the read.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      wdata_reg[i] <= mem_wdata[i];
      if (mem_wr[i]) mem_array[i][mem_addr[i]] <= wdata_reg[i];
      rd1[i] <= (fault[i] && mem_addr[i] == 4'd2) ? (mem_array[i][mem_addr[i]] & 8'hFB)
                                                   : mem_array[i][mem_addr[i]];
      rd2[i] <= rd1[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Expected per-cycle operation trace, starting at cycle 1: write flag, address and write data (-1 = don't care).
  function automatic void buildOps(input int n);
    exp_wr.delete(); exp_addr.delete(); exp_data.delete();
    for (int e = 0; e < 6; e++) begin
      int wv;
      wv = (e == 1 || e == 3) ? 255 : 0;
      exp_wr.push_back(0);
      exp_addr.push_back((e == 3 || e == 4) ? n - 1 : 0);
      exp_data.push_back((e == 5) ? -1 : wv);
      for (int i = 0; i < n; i++) begin
        int a;
        a = (e == 3 || e == 4) ? n - 1 - i : i;
        if (e != 0) begin
          exp_wr.push_back(0); exp_addr.push_back(a); exp_data.push_back(-1);
        end
        if (e != 5) begin
          exp_wr.push_back(1); exp_addr.push_back(a); exp_data.push_back(wv);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      exp_wr.push_back(0); exp_addr.push_back(-1); exp_data.push_back(-1);
    end
  endfunction

  task automatic doReset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; start[i] = 1'b0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
  endtask

  task automatic checkResetValues(input int idx, input string tag);
    checkOutput({tag, "_busy"}, busy[idx], 0);
    checkOutput({tag, "_done"}, done[idx], 0);
    checkOutput({tag, "_fail"}, fail[idx], 0);
    checkOutput({tag, "_wr"}, mem_wr[idx], 0);
    checkOutput({tag, "_addr"}, mem_addr[idx], 0);
    checkOutput({tag, "_wdata"}, mem_wdata[idx], 0);
    checkOutput({tag, "_faddr"}, fail_addr[idx], 0);
    checkOutput({tag, "_fdata"}, fail_data[idx], 0);
    checkOutput({tag, "_felem"}, fail_elem[idx], 0);
  endtask

  // Start one run and follow it until done, optionally checking the operation trace. Writes after late_cyc are counted.
  task automatic applyStimulus(input int idx, input int n, input bit keep_start, input bit trace,
                               input int late_cyc, output int done_cyc, output int late_writes);
    int k;
    buildOps(n);
    late_writes = 0;
    @(negedge clk);
    start[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    if (!keep_start) start[idx] = 1'b0;
    checkOutput("busy_after_start", busy[idx], 1);
    while (!done[idx] && k < 12 * n + 40) begin
      if (trace && k - 1 < exp_wr.size()) begin
        checkOutput($sformatf("op_wr_c%0d", k), mem_wr[idx], exp_wr[k-1]);
        if (exp_addr[k-1] >= 0) checkOutput($sformatf("op_addr_c%0d", k), mem_addr[idx], exp_addr[k-1]);
        if (exp_data[k-1] >= 0) checkOutput($sformatf("op_wdata_c%0d", k), mem_wdata[idx], exp_data[k-1]);
      end
      if (mem_wr[idx] && k > late_cyc) late_writes++;
      @(negedge clk);
      k++;
    end
    checkOutput("done_seen", done[idx], 1);
    done_cyc = done[idx] ? k : -1;
  endtask

  initial begin
    int dc;
    int lw;
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; start[i] = 1'b0; fault[i] = 1'b0; end
    fault[1] = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues(0, "reset0");
    checkResetValues(2, "reset2");
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    $display("[TB] clean run, CAPACITY=3");
    applyStimulus(0, 4, 1'b0, 1'b1, 1000, dc, lw);
    checkOutput("clean_done_cyc", dc, 49);
    checkOutput("clean_fail", fail[0], 0);
    checkOutput("clean_busy_at_done", busy[0], 0);
    for (int a = 0; a < 4; a++) checkOutput($sformatf("clean_mem%0d", a), mem_array[0][a], 0);

    $display("[TB] stuck-at fault with start held high");
    doReset();
    fault[0] = 1'b1;
    applyStimulus(0, 4, 1'b1, 1'b1, 1000, dc, lw);
    checkOutput("fault_done_cyc", dc, 49);
    checkOutput("fault_fail", fail[0], 1);
    checkOutput("fault_addr", fail_addr[0], 2);
    checkOutput("fault_data", fail_data[0], 8'hFB);
    checkOutput("fault_elem", fail_elem[0], 2);
    @(negedge clk);
    checkOutput("restart_done", done[0], 0);
    checkOutput("restart_busy", busy[0], 1);
    checkOutput("restart_fail", fail[0], 0);
    checkOutput("restart_faddr", fail_addr[0], 0);
    checkOutput("restart_fdata", fail_data[0], 0);
    start[0] = 1'b0;
    fault[0] = 1'b0;

    $display("[TB] stuck-at fault with stop on fail");
    doReset();
    applyStimulus(1, 4, 1'b0, 1'b0, 22, dc, lw);
    checkOutput("stop_done_by_23", (dc >= 21 && dc <= 23), 1);
    checkOutput("stop_late_writes", lw, 0);
    checkOutput("stop_fail", fail[1], 1);
    checkOutput("stop_addr", fail_addr[1], 2);
    checkOutput("stop_data", fail_data[1], 8'hFB);
    checkOutput("stop_elem", fail_elem[1], 2);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stop_hold_no_wr", mem_wr[1], 0);
    end

    $display("[TB] reset during E3");
    doReset();
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (27) @(negedge clk);
    checkOutput("e3_write_before_reset", mem_wr[0], 1);
    rst[0] = 1'b1;
    #1;
    checkOutput("reset_cycle_wr", mem_wr[0], 0);
    @(negedge clk);
    checkResetValues(0, "mid_reset");
    rst[0] = 1'b0;
    applyStimulus(0, 4, 1'b0, 1'b1, 1000, dc, lw);
    checkOutput("after_reset_done_cyc", dc, 49);
    checkOutput("after_reset_fail", fail[0], 0);

    $display("[TB] full address space, CAPACITY=15");
    applyStimulus(2, 16, 1'b0, 1'b1, 1000, dc, lw);
    checkOutput("full_done_cyc", dc, 169);
    checkOutput("full_fail", fail[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
